// File: rtl/blinker_core.sv
// Toggle-while-enabled blinker: out inverts once every TOGGLE_DIV consecutive
// switch-high rising edges and holds while switch is low.
module blinker_core #(
    parameter int TOGGLE_DIV = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             switch,
    output logic             out,
    output logic [CNT_W-1:0] toggle_cnt
);

    localparam int DIV_W = (TOGGLE_DIV > 1) ? $clog2(TOGGLE_DIV) : 1;

    logic div_done;

    generate
        if (TOGGLE_DIV == 1) begin : g_nodiv
            assign div_done = 1'b1;
        end else begin : g_div
            logic [DIV_W-1:0] div_q;

            assign div_done = (div_q == DIV_W'(TOGGLE_DIV - 1));

            // Any low edge restarts the period so each burst gets a full TOGGLE_DIV count.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    div_q <= '0;
                end else if (switch && !div_done) begin
                    div_q <= div_q + 1'b1;
                end else begin
                    div_q <= '0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            out        <= 1'b0;
            toggle_cnt <= '0;
        end else if (switch && div_done) begin
            out        <= ~out;
            toggle_cnt <= toggle_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_blinker_core.sv
// Self-checking bench: three blinker_core variants driven by shared stimulus and
// checked every cycle against a count-of-inversions model, plus literal checks.
module tb_blinker_core;

    logic        clk = 1'b0;
    logic        reset;
    logic        switch;
    logic        out_a, out_b, out_c;
    logic [15:0] cnt_a, cnt_b;
    logic [1:0]  cnt_c;

    int passed = 0;
    int total  = 0;

    // Model: run length of current switch-high burst and total inversions since reset.
    int div_tab [3] = '{1, 3, 1};
    int wid_tab [3] = '{16, 16, 2};
    int run_len [3];
    longint inv_n [3];
    bit model_valid = 1'b0;

    always #5 clk = ~clk;

    blinker_core #(.TOGGLE_DIV(1), .CNT_W(16)) u_a (
        .clk(clk), .reset(reset), .switch(switch), .out(out_a), .toggle_cnt(cnt_a));
    blinker_core #(.TOGGLE_DIV(3), .CNT_W(16)) u_b (
        .clk(clk), .reset(reset), .switch(switch), .out(out_b), .toggle_cnt(cnt_b));
    blinker_core #(.TOGGLE_DIV(1), .CNT_W(2)) u_c (
        .clk(clk), .reset(reset), .switch(switch), .out(out_c), .toggle_cnt(cnt_c));

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!reset) begin
                run_len[i] = 0;
                inv_n[i]   = 0;
            end else if (switch) begin
                run_len[i]++;
                if (run_len[i] % div_tab[i] == 0) inv_n[i]++;
            end else begin
                run_len[i] = 0;
            end
        end
        if (!reset) model_valid = 1'b1;
    end

    function automatic longint dut_cnt(input int i);
        case (i)
            0: return longint'(cnt_a);
            1: return longint'(cnt_b);
            default: return longint'(cnt_c);
        endcase
    endfunction

    function automatic longint dut_out(input int i);
        case (i)
            0: return longint'(out_a);
            1: return longint'(out_b);
            default: return longint'(out_c);
        endcase
    endfunction

    always @(negedge clk) begin
        if (model_valid) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("model_out[%0d]", i), dut_out(i), inv_n[i] % 2);
                chk($sformatf("model_cnt[%0d]", i), dut_cnt(i), inv_n[i] % (longint'(1) << wid_tab[i]));
            end
        end
    end

    task automatic step(input logic r, input logic s);
        reset  = r;
        switch = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_b [7] = '{0, 0, 1, 1, 1, 0, 0};
        int exp_cc [5] = '{1, 2, 3, 0, 1};
        reset  = 1'b0;
        switch = 1'b1;

        // 1: reset overrides switch, then idle
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 1'b1);
            chk("rst_out", out_a, 0);
            chk("rst_cnt", cnt_a, 0);
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0);
            chk("idle_out", out_a, 0);
        end

        // 2: two enabled edges, then hold
        step(1'b1, 1'b1); chk("b2b_e1", out_a, 1);
        step(1'b1, 1'b1); chk("b2b_e2", out_a, 0);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0);
        chk("b2b_hold_out", out_a, 0);
        chk("b2b_hold_cnt", cnt_a, 2);

        // 3: single-edge pulse
        step(1'b1, 1'b1); chk("pulse_out", out_a, 1);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0);
        chk("pulse_hold_out", out_a, 1);
        chk("pulse_hold_cnt", cnt_a, 3);
        chk("div3_short_bursts", cnt_b, 0);

        // 4: divide-by-3, then restart after one low edge
        for (int k = 0; k < 7; k++) begin
            step(1'b1, 1'b1);
            chk($sformatf("div3_e%0d", k + 1), out_b, exp_b[k]);
        end
        chk("div3_cnt", cnt_b, 2);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1); chk("div3_restart_e2", out_b, 0);
        step(1'b1, 1'b1); chk("div3_restart_e3", out_b, 1);
        chk("div3_restart_cnt", cnt_b, 3);
        chk("div1_after_div_phase", cnt_a, 13);

        // 5: reset mid-burst
        chk("pre_reset_out", out_a, 1);
        step(1'b0, 1'b1);
        chk("midrst_out", out_a, 0);
        chk("midrst_cnt", cnt_a, 0);
        step(1'b1, 1'b1);
        chk("post_rst_out", out_a, 1);

        // 6: 2-bit counter wrap
        step(1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b1);
            chk($sformatf("wrap_cnt_%0d", k + 1), cnt_c, exp_cc[k]);
            chk($sformatf("wrap_out_%0d", k + 1), out_c, (k + 1) % 2);
        end

        // Randomized bursts with occasional reset
        for (int k = 0; k < 3000; k++) begin
            logic r;
            logic s;
            r = ($urandom_range(0, 59) != 0);
            s = ($urandom_range(0, 3) != 0);
            step(r, s);
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/blinker_core.md
Name: blinker_core

Overview:
Toggle-while-enabled blinker for the bike-light output path. While `switch` is high, `out` inverts every TOGGLE_DIV enabled clock edges. With the default TOGGLE_DIV=1, `out` inverts on every rising edge. While `switch` is low, `out` holds its last value. A wrapping toggle counter is provided for status and debug.

Parameters:
TOGGLE_DIV, 1, number of consecutive switch-high rising edges per `out` inversion; legal range is at least 1.
CNT_W, 16, width of the toggle_cnt output.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
switch  input  1  blink enable; active high, sampled on the rising edge (no internal synchronizer).
out  output  1  blinker output, driven directly from a register.
toggle_cnt  output  CNT_W  count of `out` inversions since reset; wraps modulo 2^CNT_W.

Behaviour:
- Every rising edge is evaluated in this priority order: reset, then switch, then hold.
- Reset (reset=0 at a rising edge):
  - out=0, toggle_cnt=0, internal divider count div_q=0.
  - Reset overrides switch.
  - reset is not looked at between edges.
- Enabled (reset=1, switch=1):
  - If div_q == TOGGLE_DIV-1: out <= ~out, toggle_cnt <= toggle_cnt+1 (wraps), div_q <= 0.
  - Otherwise: div_q <= div_q+1; out and toggle_cnt hold.
- Disabled (reset=1, switch=0):
  - out and toggle_cnt hold.
  - div_q clears to 0, so a new enable burst always starts a full TOGGLE_DIV period.
- Latency:
  - With TOGGLE_DIV=1, the first rising edge that samples switch=1 inverts out; the new value is visible immediately after that edge.
  - Each further edge with switch=1 inverts again, so out carries a square wave of period 2 clocks.
  - With TOGGLE_DIV=N, the first inversion occurs on the Nth consecutive switch-high edge.
- Counter widths:
  - div_q is sized ceil(log2(TOGGLE_DIV)), with a minimum of 1 bit.
  - When TOGGLE_DIV=1, div_q is constant 0 and may be optimized away.
- Boundary conditions:
  - A switch pulse shorter than one clock period that straddles no rising edge has no effect.
  - Reset asserted mid-burst forces out=0 on that edge, regardless of switch.
  - After reset deasserts with switch already high, toggling begins on the first edge where reset=1.
  - toggle_cnt at 2^CNT_W-1 followed by one inversion gives toggle_cnt=0; out is unaffected by the wrap.
- No combinational path from any input to out or toggle_cnt.

Test Plan:
1. Reset hold: reset=0 for 2 edges with switch=1 -> out=0 and toggle_cnt=0 after each edge. Then reset=1, switch=0 for 3 edges -> out stays 0.
2. Back-to-back toggle (TOGGLE_DIV=1): switch=1 for exactly 2 edges -> out=1 after edge 1 and out=0 after edge 2. Then switch=0 for 5 edges -> out holds 0 and toggle_cnt=2.
3. Single-edge pulse: from out=0, switch=1 for one edge -> out=1; then switch=0 for 5 edges -> out holds 1 and toggle_cnt=3 (continuing from scenario 2).
4. Divider (TOGGLE_DIV=3): switch=1 for 7 edges -> out inverts after edges 3 and 6 only, ending at out=0 with toggle_cnt=2. Then drop switch for 1 edge and raise it again -> the next inversion occurs on the 3rd new edge, not the 2nd.
5. Reset mid-operation: out=1, switch=1, assert reset=0 for one edge -> out=0 and toggle_cnt=0. Release reset with switch=1 -> out=1 after the next edge.
6. Counter wrap (CNT_W=2): 5 consecutive toggles -> toggle_cnt sequence 1,2,3,0,1; out alternates correctly throughout.
